mem_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory (32-bit word/byte-addressed RAM with combinational read, synchronous write, byte-lane `L` mode) between the CPU data port (port 0) and the host/interface loader port (port 1). It sequences each access as a request/acknowledge transaction, registers every memory-side control so `WE` is asserted for exactly one clock, and returns read data registered per port. It sits between the core and the interface logic on one side and the memory on the other, on the same clock as the memory.

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port request/acknowledge arbiter sharing one data memory between the CPU port (0) and loader port (1).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous IDLE requests; default build gives port 0 priority.
module mem_arbiter #(
    parameter int AW = 32
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic          L0,
    input  logic          L1,
    input  logic [AW-1:0] A0,
    input  logic [AW-1:0] A1,
    input  logic [31:0]   WD0,
    input  logic [31:0]   WD1,
    output logic          ACK0,
    output logic          ACK1,
    output logic [31:0]   RD0,
    output logic [31:0]   RD1,
    output logic [AW-1:0] M_A,
    output logic          M_L,
    output logic          M_WE,
    output logic [31:0]   M_WD,
    input  logic [31:0]   M_RD,
    output logic          BUSY
);

    typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

    state_t        state;
    logic          owner;
    logic          last;
    logic          idle_pick;
    logic          sel;
    logic          sel_req;
    logic          sel_we;
    logic          sel_l;
    logic [AW-1:0] sel_a;
    logic [31:0]   sel_wd;

    always_comb begin
        if (REQ0 && REQ1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            idle_pick = ~last;
`else
            idle_pick = 1'b0;
`endif
        end else if (REQ0) begin
            idle_pick = 1'b0;
        end else if (REQ1) begin
            idle_pick = 1'b1;
        end else begin
            idle_pick = last;
        end
    end

    // In RESP the owner still holds its REQ, so only the other port may be granted.
    assign sel     = (state == RESP) ? ~owner : idle_pick;
    assign sel_req = sel ? REQ1 : REQ0;
    assign sel_we  = sel ? WE1  : WE0;
    assign sel_l   = sel ? L1   : L0;
    assign sel_a   = sel ? A1   : A0;
    assign sel_wd  = sel ? WD1  : WD0;

    // NOTE: every register here uses <= so all state updates see pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            M_A   <= '0;
            M_L   <= 1'b0;
            M_WE  <= 1'b0;
            M_WD  <= '0;
            ACK0  <= 1'b0;
            ACK1  <= 1'b0;
            RD0   <= '0;
            RD1   <= '0;
            BUSY  <= 1'b0;
        end else begin
            ACK0 <= 1'b0;
            ACK1 <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (sel_req) begin
                        M_A   <= sel_a;
                        M_L   <= sel_l;
                        M_WE  <= sel_we;
                        M_WD  <= sel_wd;
                        owner <= sel;
                        state <= SERVE;
                        BUSY  <= 1'b1;
                    end else begin
                        M_WE  <= 1'b0;
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                SERVE: begin
                    if (!M_WE) begin
                        if (owner) RD1 <= M_RD;
                        else       RD0 <= M_RD;
                    end
                    if (owner) ACK1 <= 1'b1;
                    else       ACK0 <= 1'b1;
                    last  <= owner;
                    M_WE  <= 1'b0;
                    state <= RESP;
                end
                default: begin
                    M_WE  <= 1'b0;
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: byte-level reference memory, per-port expectation queues, negedge monitor.
// Honours MEM_ARB_ROUND_ROBIN_EN for the tie-break expectation.
module tb_mem_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          we0 = 1'b0, we1 = 1'b0;
    logic          l0 = 1'b0, l1 = 1'b0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [31:0]   wd0 = '0, wd1 = '0;
    logic          ack0, ack1, m_l, m_we, busy;
    logic [31:0]   rd0, rd1, m_wd, m_rd;
    logic [AW-1:0] m_a;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int we_count = 0;
    int ack1_count = 0;

    mem_arbiter #(.AW(AW)) dut (
        .CLK(clk), .RST_N(rst_n),
        .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1), .L0(l0), .L1(l1),
        .A0(a0), .A1(a1), .WD0(wd0), .WD1(wd1),
        .ACK0(ack0), .ACK1(ack1), .RD0(rd0), .RD1(rd1),
        .M_A(m_a), .M_L(m_l), .M_WE(m_we), .M_WD(m_wd), .M_RD(m_rd),
        .BUSY(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment RAM: big-endian byte lanes, combinational read, synchronous write.
    logic [31:0] ram [0:127];
    logic [31:0] ram_word;
    assign ram_word = ram[m_a[8:2]];

    always_comb begin
        m_rd = ram_word;
        if (m_l) begin
            case (m_a[1:0])
                2'd0:    m_rd = {24'h0, ram_word[31:24]};
                2'd1:    m_rd = {24'h0, ram_word[23:16]};
                2'd2:    m_rd = {24'h0, ram_word[15:8]};
                default: m_rd = {24'h0, ram_word[7:0]};
            endcase
        end
    end

    always @(posedge clk) begin
        if (m_we) begin
            if (m_l) begin
                case (m_a[1:0])
                    2'd0:    ram[m_a[8:2]][31:24] <= m_wd[7:0];
                    2'd1:    ram[m_a[8:2]][23:16] <= m_wd[7:0];
                    2'd2:    ram[m_a[8:2]][15:8]  <= m_wd[7:0];
                    default: ram[m_a[8:2]][7:0]   <= m_wd[7:0];
                endcase
            end else begin
                ram[m_a[8:2]] <= m_wd;
            end
        end
    end

    // Reference model: flat byte array, lowest address is the most significant byte of a word.
    logic [7:0] mdl [0:511];

    function automatic logic [31:0] model_read(input logic [31:0] a, input bit l);
        int b;
        b = int'(a[8:0]) & ~3;
        if (l) return {24'h0, mdl[a[8:0]]};
        return {mdl[b], mdl[b+1], mdl[b+2], mdl[b+3]};
    endfunction

    task automatic model_write(input logic [31:0] a, input bit l, input logic [31:0] wd);
        int b;
        b = int'(a[8:0]) & ~3;
        if (l) begin
            mdl[a[8:0]] = wd[7:0];
        end else begin
            mdl[b]   = wd[31:24];
            mdl[b+1] = wd[23:16];
            mdl[b+2] = wd[15:8];
            mdl[b+3] = wd[7:0];
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          we;
        logic [31:0] rd;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e0, e1;
    logic [31:0] exp_rd0 = '0;
    logic [31:0] exp_rd1 = '0;
    logic        prev_we = 1'b0;

    // Monitor: pops an expectation on every ACK, checks held read data and write-enable shape.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_rd0 = '0;
            exp_rd1 = '0;
        end else begin
            if (ack0) begin
                check("ack0 expected", 32'(q0.size() != 0), 32'd1);
                if (q0.size() != 0) begin
                    e0 = q0.pop_front();
                    if (!e0.we) exp_rd0 = e0.rd;
                end
            end
            if (ack1) begin
                ack1_count++;
                check("ack1 expected", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    e1 = q1.pop_front();
                    if (!e1.we) exp_rd1 = e1.rd;
                end
            end
            if (ack0 || ack1) check("ack one-hot", {31'b0, ack0 & ack1}, 32'd0);
            check("rd0", rd0, exp_rd0);
            check("rd1", rd1, exp_rd1);
            if (m_we) begin
                we_count++;
                check("m_we single cycle", {31'b0, prev_we}, 32'd0);
                check("m_we only while busy", {31'b0, busy}, 32'd1);
            end
        end
        prev_we = m_we;
    end

    task automatic do_txn(input int p, input bit we, input bit l, input logic [31:0] a,
                          input logic [31:0] wd, output int ack_cyc);
        exp_t e;
        bit   got = 1'b0;
        e.we = we;
        e.rd = we ? 32'h0 : model_read(a, l);
        if (we) model_write(a, l, wd);
        if (p == 0) begin
            we0 = we; l0 = l; a0 = a; wd0 = wd; req0 = 1'b1;
            q0.push_back(e);
        end else begin
            we1 = we; l1 = l; a1 = a; wd1 = wd; req1 = 1'b1;
            q1.push_back(e);
        end
        ack_cyc = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((p == 0 && ack0) || (p == 1 && ack1)) begin
                got = 1'b1;
                ack_cyc = cyc;
                break;
            end
        end
        check($sformatf("ack%0d within budget", p), {31'b0, got}, 32'd1);
        @(posedge clk);
        #1;
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    task automatic rand_port(input int p);
        int          dummy;
        int          gap;
        bit          we, l;
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            we = 1'($urandom_range(0, 1));
            l  = 1'($urandom_range(0, 1));
            a  = (p == 1 ? 32'h100 : 32'h0) + 32'($urandom_range(0, 255));
            if (!l) a = a & ~32'h3;
            do_txn(p, we, l, a, $urandom, dummy);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ack0"}, {31'b0, ack0}, 32'd0);
        check({tag, " ack1"}, {31'b0, ack1}, 32'd0);
        check({tag, " busy"}, {31'b0, busy}, 32'd0);
        check({tag, " m_we"}, {31'b0, m_we}, 32'd0);
        check({tag, " m_l"},  {31'b0, m_l},  32'd0);
        check({tag, " m_a"},  m_a,  32'd0);
        check({tag, " m_wd"}, m_wd, 32'd0);
        check({tag, " rd0"},  rd0,  32'd0);
        check({tag, " rd1"},  rd1,  32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, c0, c1, c2, c3, w;
        for (int i = 0; i < 128; i++) ram[i] = '0;
        for (int i = 0; i < 512; i++) mdl[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle busy", {31'b0, busy}, 32'd0);

        // Simultaneous requests straight after reset: port 0 first, port 1 via RESP hand-off.
        t = cyc;
        fork
            do_txn(0, 1'b1, 1'b0, 32'h40,  32'hA5A5A5A5, c0);
            do_txn(1, 1'b1, 1'b0, 32'h140, 32'h0F0F0F0F, c1);
        join
        check("both: port0 latency", c0 - t, 32'd2);
        check("both: port1 latency", c1 - t, 32'd4);

        // Port 0 word write then read back.
        t = cyc;
        w = we_count;
        do_txn(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, c0);
        check("p0 write latency", c0 - t, 32'd2);
        check("p0 write m_we cycles", we_count - w, 32'd1);
        t = cyc;
        do_txn(0, 1'b0, 1'b0, 32'h10, 32'h0, c0);
        check("p0 read latency", c0 - t, 32'd2);
        check("p0 read data", rd0, 32'hDEADBEEF);
        check("p0 read no m_we", we_count - w, 32'd1);

        // Port 1 byte-lane merge.
        do_txn(1, 1'b1, 1'b0, 32'h10, 32'h11223344, c0);
        do_txn(1, 1'b1, 1'b1, 32'h13, 32'h0000005A, c0);
        do_txn(1, 1'b0, 1'b0, 32'h10, 32'h0, c0);
        check("p1 merged word", rd1, 32'h1122335A);
        check("rd0 untouched by port 1", rd0, 32'hDEADBEEF);
        do_txn(1, 1'b0, 1'b1, 32'h13, 32'h0, c0);
        check("p1 byte read", rd1, 32'h0000005A);

        // Continuous port 0 with a single port 1 request raised during port 0 SERVE.
        t = cyc;
        fork
            begin
                do_txn(0, 1'b0, 1'b0, 32'h10, 32'h0, c0);
                do_txn(0, 1'b0, 1'b0, 32'h10, 32'h0, c1);
                do_txn(0, 1'b0, 1'b0, 32'h10, 32'h0, c2);
            end
            begin
                @(posedge clk);
                #1;
                do_txn(1, 1'b0, 1'b0, 32'h12, 32'h0, c3);
            end
        join
        check("handoff ack0 #1", c0 - t, 32'd2);
        check("handoff ack1", c3 - t, 32'd4);
        check("handoff ack0 #2", c1 - t, 32'd6);
        check("handoff ack0 #3", c2 - t, 32'd9);

        // One-cycle REQ1 glitch while port 0 is in SERVE must be ignored.
        w = ack1_count;
        fork
            do_txn(0, 1'b1, 1'b0, 32'h30, 32'h01020304, c0);
            begin
                @(posedge clk);
                #1;
                req1 = 1'b1; we1 = 1'b1; l1 = 1'b0; a1 = 32'h30; wd1 = 32'hFFFFFFFF;
                @(posedge clk);
                #1;
                req1 = 1'b0; we1 = 1'b0;
            end
        join
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("glitch: no ack1", ack1_count - w, 32'd0);
        do_txn(0, 1'b0, 1'b0, 32'h30, 32'h0, c0);
        check("glitch: p0 data kept", rd0, 32'h01020304);

        // Tie in IDLE after port 0 was served last.
        t = cyc;
        fork
            do_txn(0, 1'b0, 1'b0, 32'h30,  32'h0, c0);
            do_txn(1, 1'b0, 1'b0, 32'h140, 32'h0, c1);
        join
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check("tie: port1 latency", c1 - t, 32'd2);
        check("tie: port0 latency", c0 - t, 32'd4);
`else
        check("tie: port0 latency", c0 - t, 32'd2);
        check("tie: port1 latency", c1 - t, 32'd4);
`endif

        // Reset asserted in the SERVE cycle of a write.
        do_txn(0, 1'b1, 1'b0, 32'h20, 32'hCAFEF00D, c0);
        w = we_count;
        we0 = 1'b1; l0 = 1'b0; a0 = 32'h20; wd0 = 32'h12345678; req0 = 1'b1;
        @(posedge clk);
        #1;
        check("pre-reset busy", {31'b0, busy}, 32'd1);
        check("pre-reset m_we", {31'b0, m_we}, 32'd1);
        check("pre-reset m_a", m_a, 32'h20);
        rst_n = 1'b0;
        req0 = 1'b0;
        we0 = 1'b0;
        #1;
        check_reset_outputs("mid-serve reset");
        repeat (2) @(posedge clk);
        #1;
        check("reset: ram 0x20 kept", ram[8], 32'hCAFEF00D);
        check("reset: no write seen", we_count - w, 32'd0);
        check("reset: ack0 low", {31'b0, ack0}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_txn(0, 1'b0, 1'b0, 32'h20, 32'h0, c0);
        check("reset: readback 0x20", rd0, 32'hCAFEF00D);

        // Randomised traffic, each port in its own address region.
        fork
            rand_port(0);
            rand_port(1);
        join

        repeat (5) @(posedge clk);
        #1;
        check("q0 drained", 32'(q0.size()), 32'd0);
        check("q1 drained", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
